// File: rtl/idu_decode_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, unit classes and immediate formats.
package idu_decode_stage_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        UNIT_ALU_R  = 3'd0,
        UNIT_ALU_I  = 3'd1,
        UNIT_LOAD   = 3'd2,
        UNIT_STORE  = 3'd3,
        UNIT_BRANCH = 3'd4,
        UNIT_JUMP   = 3'd5,
        UNIT_UPPER  = 3'd6,
        UNIT_SYSTEM = 3'd7
    } unit_e;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

    // FENCE and SYSTEM carry an I-format field; R-type and unknown opcodes have none.
    function automatic imm_fmt_e imm_format(input logic [6:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR,
            OPC_MISC_MEM, OPC_SYSTEM:  fmt = FMT_I;
            OPC_STORE:                 fmt = FMT_S;
            OPC_BRANCH:                fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:        fmt = FMT_U;
            OPC_JAL:                   fmt = FMT_J;
            default:                   fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/idu_imm_gen.sv
// Combinational RV32I immediate generator; illegal instructions yield zero.
module idu_imm_gen
    import idu_decode_stage_pkg::*;
(
    input  logic [31:0] ins,
    input  logic        legal,
    output logic [31:0] imm
);

    imm_fmt_e fmt;

    always_comb begin
        fmt = legal ? imm_format(ins[6:0]) : FMT_NONE;
        case (fmt)
            FMT_I:   imm = {{21{ins[31]}}, ins[30:20]};
            FMT_S:   imm = {{21{ins[31]}}, ins[30:25], ins[11:7]};
            FMT_B:   imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   imm = {ins[31:12], 12'h000};
            FMT_J:   imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/idu_decode_stage.sv
// RV32I decode stage: 2-entry skid buffer feeding a registered decoded-output stage.
module idu_decode_stage
    import idu_decode_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  idu_clock_in,
    input  logic                  idu_reset_in,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic [DATA_WIDTH-1:0] ins_in,
    input  logic                  ins_valid_in,
    output logic                  ins_ready_out,
    input  logic                  flush_in,
    output logic                  dec_valid_out,
    input  logic                  dec_ready_in,
    output logic [ADDR_WIDTH-1:0] dec_pc_out,
    output logic [4:0]            dec_rs1_out,
    output logic [4:0]            dec_rs2_out,
    output logic [4:0]            dec_rd_out,
    output logic [DATA_WIDTH-1:0] dec_imm_out,
    output logic [2:0]            dec_unit_out,
    output logic [3:0]            dec_funct_out,
    output logic                  dec_rd_we_out,
    output logic                  dec_illegal_out
);

    logic [1:0]            count;
    logic [ADDR_WIDTH-1:0] buf_pc  [2];
    logic [DATA_WIDTH-1:0] buf_ins [2];

    logic                  in_fire;
    logic                  out_load;
    logic                  pop;
    logic                  push;
    logic                  wr_idx;
    logic [ADDR_WIDTH-1:0] src_pc;
    logic [DATA_WIDTH-1:0] src_ins;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic                  legal;
    logic                  use_bit30;
    logic                  rd_we;
    unit_e                 unit;
    logic [DATA_WIDTH-1:0] imm;

    // Ready depends only on the buffer fill and reset, never on dec_ready_in.
    assign ins_ready_out = (count != 2'd2) && !idu_reset_in;

    always_comb begin
        in_fire  = ins_valid_in && ins_ready_out;
        out_load = !dec_valid_out || dec_ready_in;
        pop      = out_load && (count != 2'd0);
        push     = in_fire && !flush_in && !(out_load && (count == 2'd0));
        wr_idx   = (count == 2'd1) && !pop;
        src_pc   = (count != 2'd0) ? buf_pc[0]  : pc_in;
        src_ins  = (count != 2'd0) ? buf_ins[0] : ins_in;
    end

    assign opcode = src_ins[6:0];
    assign funct3 = src_ins[14:12];
    assign funct7 = src_ins[31:25];

    // Opcodes all end in 2'b11, so a bad low pair falls into the default arm.
    always_comb begin
        legal     = 1'b1;
        unit      = UNIT_ALU_R;
        use_bit30 = 1'b0;
        case (opcode)
            OPC_LOAD: begin
                unit  = UNIT_LOAD;
                legal = !(funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
            end
            OPC_STORE: begin
                unit  = UNIT_STORE;
                legal = (funct3 <= 3'd2);
            end
            OPC_BRANCH: begin
                unit  = UNIT_BRANCH;
                legal = (funct3[2:1] != 2'b01);
            end
            OPC_OP: begin
                unit      = UNIT_ALU_R;
                use_bit30 = 1'b1;
                legal     = (funct7 == 7'h00) ||
                            ((funct7 == 7'h20) && (funct3 == 3'd0 || funct3 == 3'd5));
            end
            OPC_OP_IMM: begin
                unit = UNIT_ALU_I;
                if (funct3 == 3'd1) begin
                    use_bit30 = 1'b1;
                    legal     = (funct7 == 7'h00);
                end else if (funct3 == 3'd5) begin
                    use_bit30 = 1'b1;
                    legal     = (funct7 == 7'h00) || (funct7 == 7'h20);
                end
            end
            OPC_JALR: begin
                unit  = UNIT_JUMP;
                legal = (funct3 == 3'd0);
            end
            OPC_JAL:                  unit  = UNIT_JUMP;
            OPC_LUI, OPC_AUIPC:       unit  = UNIT_UPPER;
            OPC_MISC_MEM, OPC_SYSTEM: unit  = UNIT_SYSTEM;
            default:                  legal = 1'b0;
        endcase
        rd_we = legal && (src_ins[11:7] != 5'd0) &&
                (unit != UNIT_STORE) && (unit != UNIT_BRANCH) && (unit != UNIT_SYSTEM);
    end

    idu_imm_gen u_imm_gen (
        .ins   (src_ins),
        .legal (legal),
        .imm   (imm)
    );

    always_ff @(posedge idu_clock_in) begin
        if (idu_reset_in) begin
            count           <= 2'd0;
            dec_valid_out   <= 1'b0;
            dec_pc_out      <= '0;
            dec_rs1_out     <= '0;
            dec_rs2_out     <= '0;
            dec_rd_out      <= '0;
            dec_imm_out     <= '0;
            dec_unit_out    <= '0;
            dec_funct_out   <= '0;
            dec_rd_we_out   <= 1'b0;
            dec_illegal_out <= 1'b0;
        end else if (flush_in) begin
            count         <= 2'd0;
            dec_valid_out <= 1'b0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (out_load) begin
                dec_valid_out <= pop || in_fire;
                if (pop || in_fire) begin
                    dec_pc_out      <= src_pc;
                    dec_rs1_out     <= src_ins[19:15];
                    dec_rs2_out     <= src_ins[24:20];
                    dec_rd_out      <= src_ins[11:7];
                    dec_imm_out     <= imm;
                    dec_unit_out    <= unit;
                    dec_funct_out   <= {use_bit30 & src_ins[30], funct3};
                    dec_rd_we_out   <= rd_we;
                    dec_illegal_out <= !legal;
                end
            end
        end
    end

    // Storage only; validity of each slot is tracked by count.
    always_ff @(posedge idu_clock_in) begin
        if (pop) begin
            buf_pc[0]  <= buf_pc[1];
            buf_ins[0] <= buf_ins[1];
        end
        if (push) begin
            buf_pc[wr_idx]  <= pc_in;
            buf_ins[wr_idx] <= ins_in;
        end
    end

endmodule
